// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 constants and receiver state encoding
package crc_pkg;

  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY_DEFAULT = 8'h07;
  localparam logic [CRC_W-1:0] CRC_INIT_DEFAULT = 8'h00;

  // Wide enough for DATA_BITS up to 32 and the 8 CRC bits.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// rtl/crc_lfsr_step.sv - combinational one-bit MSB-first CRC LFSR update
module crc_lfsr_step
  import crc_pkg::*;
(
  input  logic [CRC_W-1:0] crc,
  input  logic             din,
  input  logic [CRC_W-1:0] poly,
  output logic [CRC_W-1:0] crc_next
);

  logic fb;

  assign fb       = crc[CRC_W-1] ^ din;
  assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ (poly & {CRC_W{fb}});

endmodule

// File: rtl/crc8_serial_rx.sv
// rtl/crc8_serial_rx.sv - bit-serial CRC-8 frame receiver
// Optional error counter (err_cnt/err_clr) enabled by CRC8_RX_ERR_CNT_EN.
module crc8_serial_rx
  import crc_pkg::*;
#(
  parameter int               DATA_BITS = 8,
  parameter logic [CRC_W-1:0] POLY      = CRC_POLY_DEFAULT,
  parameter logic [CRC_W-1:0] INIT      = CRC_INIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_vld,
  input  logic                 sof,
`ifdef CRC8_RX_ERR_CNT_EN
  input  logic                 err_clr,
  output logic [7:0]           err_cnt,
`endif
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_vld,
  output logic                 crc_ok,
  output logic                 busy
);

  rx_state_e            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CRC_W-1:0]     crc, crc_nxt;
  logic [DATA_BITS-1:0] sr, sr_nxt, sr_shift;
  logic [CRC_W-1:0]     step_in, step_out;
  logic                 start, done;

  assign start    = bit_vld & sof;
  // A new frame always starts from INIT, even when it aborts one in flight.
  assign step_in  = start ? INIT : crc;
  assign sr_shift = DATA_BITS'({sr, bit_in});

  crc_lfsr_step u_step (
    .crc      (step_in),
    .din      (bit_in),
    .poly     (POLY),
    .crc_next (step_out)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    crc_nxt   = crc;
    sr_nxt    = sr;
    done      = 1'b0;
    if (start) begin
      crc_nxt = step_out;
      sr_nxt  = sr_shift;
      if (DATA_BITS == 1) begin
        state_nxt = CRC;
        cnt_nxt   = '0;
      end else begin
        state_nxt = DATA;
        cnt_nxt   = CNT_W'(1);
      end
    end else if (bit_vld) begin
      case (state)
        DATA: begin
          crc_nxt = step_out;
          sr_nxt  = sr_shift;
          if (cnt == CNT_W'(DATA_BITS - 1)) begin
            state_nxt = CRC;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        CRC: begin
          crc_nxt = step_out;
          if (cnt == CNT_W'(CRC_W - 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done      = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      crc   <= INIT;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      crc   <= crc_nxt;
      sr    <= sr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      frame_vld <= 1'b0;
      crc_ok    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_vld <= done;
      busy      <= (state_nxt != IDLE);
      if (done) begin
        data_out <= sr;
        crc_ok   <= (crc_nxt == '0);
      end
    end
  end

`ifdef CRC8_RX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
    end else if (err_clr) begin
      err_cnt <= 8'h00;
    end else if (frame_vld && !crc_ok && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_crc8_serial_rx.sv
// tb/tb_crc8_serial_rx.sv - directed self-checking bench for crc8_serial_rx
module tb_crc8_serial_rx;

  localparam int DATA_BITS = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 bit_in = 1'b0;
  logic                 bit_vld = 1'b0;
  logic                 sof = 1'b0;
  logic [DATA_BITS-1:0] data_out;
  logic                 frame_vld;
  logic                 crc_ok;
  logic                 busy;
`ifdef CRC8_RX_ERR_CNT_EN
  logic                 err_clr = 1'b0;
  logic [7:0]           err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int dut_frames = 0;
  int dut_ok_frames = 0;

  crc8_serial_rx #(.DATA_BITS(DATA_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .sof       (sof),
`ifdef CRC8_RX_ERR_CNT_EN
    .err_clr   (err_clr),
    .err_cnt   (err_cnt),
`endif
    .data_out  (data_out),
    .frame_vld (frame_vld),
    .crc_ok    (crc_ok),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Remainder of (payload . crc) modulo x^8+x^2+x+1 by polynomial long division.
  function automatic logic model_ok(input logic [7:0] p, input logic [7:0] c);
    logic [15:0] v;
    v = {p, c};
    for (int i = 15; i >= 8; i--)
      if (v[i]) v = v ^ (16'h0107 << (i - 8));
    return (v == 16'h0000);
  endfunction

  logic [15:0] acc = '0;
  int          nbits = 0;
  logic        active = 1'b0;
  logic        exp_fv = 1'b0;
  logic        exp_busy = 1'b0;
  logic [7:0]  exp_data = '0;
  logic        exp_ok = 1'b0;
  logic [7:0]  exp_err = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc = '0; nbits = 0; active = 1'b0;
      exp_fv = 1'b0; exp_busy = 1'b0; exp_data = '0; exp_ok = 1'b0; exp_err = '0;
    end else begin
      if (exp_fv && !exp_ok && exp_err != 8'hFF) exp_err = exp_err + 8'h01;
      exp_fv = 1'b0;
      if (bit_vld && sof) begin
        active = 1'b1; acc = {15'b0, bit_in}; nbits = 1;
      end else if (bit_vld && active) begin
        acc = {acc[14:0], bit_in}; nbits++;
      end
      if (active && nbits == DATA_BITS + 8) begin
        active   = 1'b0;
        exp_fv   = 1'b1;
        exp_data = acc[15:8];
        exp_ok   = model_ok(acc[15:8], acc[7:0]);
      end
      exp_busy = active;
    end
  end

  always @(negedge clk) begin
    chk("frame_vld", {31'b0, frame_vld}, {31'b0, exp_fv});
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    chk("data_out", {24'b0, data_out}, {24'b0, exp_data});
    chk("crc_ok", {31'b0, crc_ok}, {31'b0, exp_ok});
`ifdef CRC8_RX_ERR_CNT_EN
    chk("err_cnt", {24'b0, err_cnt}, {24'b0, exp_err});
`endif
    if (frame_vld) begin
      dut_frames++;
      if (crc_ok) dut_ok_frames++;
    end
  end

  task automatic drive(input logic v, input logic b, input logic s);
    bit_vld = v; bit_in = b; sof = s;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, v[7-i], i == 0);
  endtask

  task automatic send_frame(input logic [7:0] p, input logic [7:0] c, input logic gap);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i < 8) ? p[7-i] : c[15-i], i == 0);
      if (gap) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  int f0, k0;

  initial begin
    chk("model_good", {31'b0, model_ok(8'h31, 8'h97)}, 32'd1);
    chk("model_bad", {31'b0, model_ok(8'h31, 8'h96)}, 32'd0);
    chk("model_zero", {31'b0, model_ok(8'h00, 8'h00)}, 32'd1);

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_fv", {31'b0, frame_vld}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_data", {24'b0, data_out}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    idle(3);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_crc_ok", {31'b0, crc_ok}, 32'd0);

    f0 = dut_frames; k0 = dut_ok_frames;
    send_frame(8'h31, 8'h97, 1'b0);
    chk("good_fv_now", {31'b0, frame_vld}, 32'd1);
    idle(2);
    chk("good_frames", dut_frames - f0, 32'd1);
    chk("good_data", {24'b0, data_out}, 32'h31);
    chk("good_ok", {31'b0, crc_ok}, 32'd1);

    f0 = dut_frames;
    send_frame(8'h31, 8'h96, 1'b0);
    idle(2);
    chk("bad_frames", dut_frames - f0, 32'd1);
    chk("bad_ok", {31'b0, crc_ok}, 32'd0);
`ifdef CRC8_RX_ERR_CNT_EN
    chk("bad_err_cnt", {24'b0, err_cnt}, 32'd1);
`endif

    f0 = dut_frames;
    send_frame(8'h00, 8'h00, 1'b1);
    idle(2);
    chk("gap_frames", dut_frames - f0, 32'd1);
    chk("gap_data", {24'b0, data_out}, 32'h00);
    chk("gap_ok", {31'b0, crc_ok}, 32'd1);

    f0 = dut_frames; k0 = dut_ok_frames;
    send_bits(8'hA5, 5);
    send_frame(8'h31, 8'h97, 1'b0);
    idle(2);
    chk("abort_frames", dut_frames - f0, 32'd1);
    chk("abort_ok_frames", dut_ok_frames - k0, 32'd1);

    f0 = dut_frames;
    send_bits(8'h31, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(20);
    chk("rst_mid_frames", dut_frames - f0, 32'd0);
    chk("rst_mid_busy2", {31'b0, busy}, 32'd0);

    f0 = dut_frames; k0 = dut_ok_frames;
    send_frame(8'h31, 8'h97, 1'b0);
    chk("b2b_first_fv", {31'b0, frame_vld}, 32'd1);
    send_frame(8'h31, 8'h97, 1'b0);
    idle(3);
    chk("b2b_frames", dut_frames - f0, 32'd2);
    chk("b2b_ok_frames", dut_ok_frames - k0, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
